// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM state encoding and ACK/NACK bit levels.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } i2c_tgt_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam int I2C_MEM_DEPTH = 128;

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers for SCL/SDA plus single-cycle edge and START/STOP pulses.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);
    logic r_scl_meta, r_scl_sync, r_scl_prev;
    logic r_sda_meta, r_sda_sync, r_sda_prev;
    logic w_scl_chg;

    // Idle bus is high; resetting to 1 avoids phantom edges on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_meta <= i_scl;
            r_scl_sync <= r_scl_meta;
            r_scl_prev <= r_scl_sync;
            r_sda_meta <= i_sda;
            r_sda_sync <= r_sda_meta;
            r_sda_prev <= r_sda_sync;
        end
    end

    assign w_scl_chg  = r_scl_sync ^ r_scl_prev;
    assign o_sda      = r_sda_sync;
    assign o_scl_rise = r_scl_sync & ~r_scl_prev;
    assign o_scl_fall = ~r_scl_sync & r_scl_prev;
    // An SDA move in the same sampled cycle as an SCL move is data, not a condition.
    assign o_start    = ~w_scl_chg & r_scl_sync & r_sda_prev & ~r_sda_sync;
    assign o_stop     = ~w_scl_chg & r_scl_sync & ~r_sda_prev & r_sda_sync;

endmodule

// File: rtl/i2c_target_mem.sv
// I2C target with a 128x8 register file: pointer write, data write/read, auto-increment.
module i2c_target_mem
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       busy,
    output logic       wr_pulse,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data
);
    logic w_sda, w_rise, w_fall, w_start, w_stop;
    logic [7:0] w_byte;

    i2c_tgt_state_t r_state;
    logic [3:0]     r_cnt;
    logic [7:0]     r_shift;
    logic [6:0]     r_ptr;
    logic           r_rw, r_mack;
    logic           r_sda_oe, r_busy, r_wr_pulse;
    logic [6:0]     r_wr_addr;
    logic [7:0]     r_wr_data;
    logic [7:0]     r_mem [0:I2C_MEM_DEPTH-1];

    i2c_bus_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .i_scl      (scl_i),
        .i_sda      (sda_i),
        .o_sda      (w_sda),
        .o_scl_rise (w_rise),
        .o_scl_fall (w_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    assign w_byte = {r_shift[6:0], w_sda};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_ptr      <= '0;
            r_rw       <= 1'b0;
            r_mack     <= I2C_NACK;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_pulse <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            for (int i = 0; i < I2C_MEM_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_wr_pulse <= 1'b0;
            if (w_start) begin
                r_state  <= ST_ADDR;
                r_cnt    <= '0;
                r_sda_oe <= 1'b0;
            end else if (w_stop) begin
                r_state  <= ST_IDLE;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    ST_ADDR: begin
                        if (w_rise) begin
                            r_shift <= w_byte;
                            r_cnt   <= r_cnt + 4'd1;
                        end else if (w_fall && r_cnt == 4'd8) begin
                            if (r_shift[7:1] == DEV_ADDR) begin
                                r_rw     <= r_shift[0];
                                r_busy   <= 1'b1;
                                r_sda_oe <= 1'b1;
                                r_state  <= ST_ADDR_ACK;
                            end else begin
                                r_busy  <= 1'b0;
                                r_state <= ST_IGNORE;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (w_fall) begin
                            r_cnt <= '0;
                            if (r_rw) begin
                                // First read bit goes out on the edge that ends the ACK.
                                r_shift  <= r_mem[r_ptr];
                                r_sda_oe <= ~r_mem[r_ptr][7];
                                r_state  <= ST_RDATA;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_state  <= ST_PTR;
                            end
                        end
                    end
                    ST_PTR: begin
                        if (w_rise) begin
                            r_shift <= w_byte;
                            r_cnt   <= r_cnt + 4'd1;
                        end else if (w_fall && r_cnt == 4'd8) begin
                            r_ptr    <= r_shift[6:0];
                            r_sda_oe <= 1'b1;
                            r_state  <= ST_PTR_ACK;
                        end
                    end
                    ST_PTR_ACK, ST_WDATA_ACK: begin
                        if (w_fall) begin
                            r_sda_oe <= 1'b0;
                            r_cnt    <= '0;
                            r_state  <= ST_WDATA;
                        end
                    end
                    ST_WDATA: begin
                        if (w_rise) begin
                            r_shift <= w_byte;
                            r_cnt   <= r_cnt + 4'd1;
                            if (r_cnt == 4'd7) begin
                                r_mem[r_ptr] <= w_byte;
                                r_wr_pulse   <= 1'b1;
                                r_wr_addr    <= r_ptr;
                                r_wr_data    <= w_byte;
                                r_ptr        <= r_ptr + 7'd1;
                            end
                        end else if (w_fall && r_cnt == 4'd8) begin
                            r_sda_oe <= 1'b1;
                            r_state  <= ST_WDATA_ACK;
                        end
                    end
                    ST_RDATA: begin
                        if (w_rise) begin
                            r_cnt <= r_cnt + 4'd1;
                        end else if (w_fall) begin
                            if (r_cnt == 4'd8) begin
                                r_sda_oe <= 1'b0;
                                r_ptr    <= r_ptr + 7'd1;
                                r_state  <= ST_RDATA_ACK;
                            end else begin
                                r_shift  <= {r_shift[6:0], 1'b0};
                                r_sda_oe <= ~r_shift[6];
                            end
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (w_rise) begin
                            r_mack <= w_sda;
                        end else if (w_fall) begin
                            r_cnt <= '0;
                            if (r_mack == I2C_ACK) begin
                                r_shift  <= r_mem[r_ptr];
                                r_sda_oe <= ~r_mem[r_ptr][7];
                                r_state  <= ST_RDATA;
                            end else begin
                                r_busy  <= 1'b0;
                                r_state <= ST_IGNORE;
                            end
                        end
                    end
                    default: r_sda_oe <= 1'b0;
                endcase
            end
        end
    end

    assign sda_oe   = r_sda_oe;
    assign busy     = r_busy;
    assign wr_pulse = r_wr_pulse;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;

endmodule

// File: tb/tb_i2c_target_mem.sv
// Bench for i2c_target_mem: bit-banged I2C initiator, directed table, corner sequences, random traffic vs. a memory model.
module tb_i2c_target_mem;
    import i2c_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_line;
    logic       sda_oe, busy, wr_pulse;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;

    assign sda_line = m_sda & ~sda_oe;
    always #5 clk = ~clk;

    i2c_target_mem #(.DEV_ADDR(7'h50)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (m_scl),
        .sda_i    (sda_line),
        .sda_oe   (sda_oe),
        .busy     (busy),
        .wr_pulse (wr_pulse),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Bus observers.
    int         pulse_cnt = 0;
    logic [6:0] last_addr;
    logic [7:0] last_data;
    bit         oe_seen = 0;
    always @(negedge clk) begin
        if (wr_pulse === 1'b1) begin
            pulse_cnt++;
            last_addr = wr_addr;
            last_data = wr_data;
        end
        if (sda_oe === 1'b1) oe_seen = 1;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Initiator primitives: one bit = four quarter periods of 4 clk each.
    task automatic qp();
        repeat (4) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; qp();
        m_scl = 1'b1; qp();
        m_sda = 1'b0; qp();
        m_scl = 1'b0; qp();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; qp();
        m_scl = 1'b1; qp();
        m_sda = 1'b1; qp();
    endtask

    task automatic bit_io(input logic b, output logic s);
        m_sda = b;    qp();
        m_scl = 1'b1; qp();
        s = sda_line; qp();
        m_scl = 1'b0; qp();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_io(b[i], s);
        bit_io(1'b1, s);
        ack = (s == I2C_ACK);
    endtask

    task automatic recv_byte(input logic last, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, s);
            b[i] = s;
        end
        bit_io(last ? I2C_NACK : I2C_ACK, s);
    endtask

    task automatic tx_write(input logic [6:0] dev, input logic [7:0] idx, input int n,
                            input logic [3:0][7:0] d, output int acks);
        logic a;
        acks = 0;
        i2c_start();
        send_byte({dev, 1'b0}, a);
        if (a) begin
            acks++;
            send_byte(idx, a);
            if (a) acks++;
            for (int k = 0; k < n; k++) begin
                send_byte(d[k], a);
                if (a) acks++;
            end
        end
        i2c_stop();
    endtask

    task automatic tx_read(input logic [6:0] dev, input logic [7:0] idx, input bit setp,
                           input int n, output logic [3:0][7:0] r, output int acks);
        logic a;
        acks = 0;
        r = '0;
        i2c_start();
        a = 1'b1;
        if (setp) begin
            send_byte({dev, 1'b0}, a);
            if (a) begin
                acks++;
                send_byte(idx, a);
                if (a) acks++;
                i2c_start();
            end
        end
        if (a) begin
            send_byte({dev, 1'b1}, a);
            if (a) begin
                acks++;
                for (int k = 0; k < n; k++) recv_byte(k == n - 1, r[k]);
            end
        end
        i2c_stop();
    endtask

    typedef struct {
        bit              rd;
        bit              setp;
        logic [6:0]      dev;
        logic [7:0]      idx;
        int              n;
        logic [3:0][7:0] d;
        int              exp_acks;
        int              exp_pulses;
        logic [6:0]      exp_waddr;
        logic [7:0]      exp_wdata;
        logic [3:0][7:0] exp_rd;
    } vec_t;

    function automatic vec_t mkv(bit rd, bit setp, logic [6:0] dev, logic [7:0] idx, int n,
                                 logic [3:0][7:0] d, int acks, int pulses, logic [6:0] wa,
                                 logic [7:0] wd, logic [3:0][7:0] erd);
        vec_t v;
        v.rd = rd; v.setp = setp; v.dev = dev; v.idx = idx; v.n = n; v.d = d;
        v.exp_acks = acks; v.exp_pulses = pulses; v.exp_waddr = wa; v.exp_wdata = wd;
        v.exp_rd = erd;
        return v;
    endfunction

    // Reference: the register file and pointer as seen by the initiator.
    logic [7:0] mm [128];
    logic [6:0] mp;

    task automatic model_reset();
        for (int i = 0; i < 128; i++) mm[i] = 8'h00;
        mp = 7'h00;
    endtask

    task automatic model_run(inout vec_t v);
        bit hit;
        hit = (v.dev == 7'h50);
        v.exp_pulses = 0;
        v.exp_rd = '0;
        if (!hit) begin
            v.exp_acks = 0;
        end else if (!v.rd) begin
            v.exp_acks = 2 + v.n;
            mp = v.idx[6:0];
            for (int k = 0; k < v.n; k++) begin
                mm[mp] = v.d[k];
                v.exp_waddr = mp;
                v.exp_wdata = v.d[k];
                v.exp_pulses++;
                mp = 7'((int'(mp) + 1) % 128);
            end
        end else begin
            v.exp_acks = v.setp ? 3 : 1;
            if (v.setp) mp = v.idx[6:0];
            for (int k = 0; k < v.n; k++) begin
                v.exp_rd[k] = mm[mp];
                mp = 7'((int'(mp) + 1) % 128);
            end
        end
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        logic [3:0][7:0] r;
        int acks;
        pulse_cnt = 0;
        oe_seen   = 0;
        r = '0;
        if (v.rd) tx_read(v.dev, v.idx, v.setp, v.n, r, acks);
        else      tx_write(v.dev, v.idx, v.n, v.d, acks);
        qp();
        check({nm, "_acks"}, acks, v.exp_acks);
        check({nm, "_pulses"}, pulse_cnt, v.exp_pulses);
        if (v.exp_pulses > 0) begin
            check({nm, "_wr_addr"}, last_addr, v.exp_waddr);
            check({nm, "_wr_data"}, last_data, v.exp_wdata);
        end
        if (v.rd && v.exp_acks > 0)
            for (int k = 0; k < v.n; k++) check($sformatf("%s_rd%0d", nm, k), r[k], v.exp_rd[k]);
        if (v.exp_acks == 0) check({nm, "_oe_quiet"}, oe_seen, 0);
        check({nm, "_busy_idle"}, busy, 1'b0);
    endtask

    vec_t tbl [8];

    initial begin
        vec_t v;
        logic s, a;

        tbl[0] = mkv(0, 1, 7'h50, 8'h10, 1, {24'h0, 8'hA5},   3, 1, 7'h10, 8'hA5, '0);
        tbl[1] = mkv(1, 1, 7'h50, 8'h10, 1, '0,               3, 0, 7'h00, 8'h00, {24'h0, 8'hA5});
        tbl[2] = mkv(0, 1, 7'h51, 8'h10, 1, {24'h0, 8'h5A},   0, 0, 7'h00, 8'h00, '0);
        tbl[3] = mkv(1, 1, 7'h50, 8'h10, 1, '0,               3, 0, 7'h00, 8'h00, {24'h0, 8'hA5});
        tbl[4] = mkv(0, 1, 7'h50, 8'h7F, 2, {16'h0, 16'h2211}, 4, 2, 7'h00, 8'h22, '0);
        tbl[5] = mkv(1, 1, 7'h50, 8'h7F, 2, '0,               3, 0, 7'h00, 8'h00, {16'h0, 16'h2211});
        tbl[6] = mkv(1, 0, 7'h50, 8'h00, 1, '0,               1, 0, 7'h00, 8'h00, '0);
        tbl[7] = mkv(1, 0, 7'h51, 8'h00, 1, '0,               0, 0, 7'h00, 8'h00, '0);

        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_sda_oe",  sda_oe,   1'b0);
        check("reset_busy",    busy,     1'b0);
        check("reset_wr_pulse", wr_pulse, 1'b0);
        check("reset_wr_addr", wr_addr,  7'h00);
        check("reset_wr_data", wr_data,  8'h00);
        rst = 1'b0;
        qp();

        for (int i = 0; i < 8; i++) begin
            v = tbl[i];
            run_vec($sformatf("tbl%0d", i), v);
            model_run(v);
        end

        // Reset asserted while the target drives bit 4 of a read of 0xA5 (that bit is 0).
        i2c_start();
        send_byte(8'hA0, a);
        send_byte(8'h10, a);
        i2c_start();
        send_byte(8'hA1, a);
        check("rr_addr_ack", a, 1'b1);
        for (int i = 0; i < 3; i++) bit_io(1'b1, s);
        m_sda = 1'b1; qp();
        m_scl = 1'b1; qp();
        check("rr_bit4_driven", sda_oe, 1'b1);
        rst = 1'b1;
        #1;
        check("rr_oe_released", sda_oe, 1'b0);
        check("rr_busy_cleared", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        qp();
        m_scl = 1'b0; qp();
        i2c_stop();
        qp();
        v = mkv(1, 1, 7'h50, 8'h10, 1, '0, 3, 0, 7'h00, 8'h00, '0);
        run_vec("rr_mem_cleared", v);
        model_run(v);
        v = mkv(0, 1, 7'h50, 8'h10, 1, {24'h0, 8'h77}, 3, 1, 7'h10, 8'h77, '0);
        run_vec("rr_rewrite", v);
        model_run(v);
        v = mkv(1, 1, 7'h50, 8'h10, 1, '0, 3, 0, 7'h00, 8'h00, {24'h0, 8'h77});
        run_vec("rr_reread", v);
        model_run(v);

        // STOP after 4 data bits: no write, pointer left at 0x20.
        v = mkv(0, 1, 7'h50, 8'h20, 2, {16'h0, 16'h4D3C}, 4, 2, 7'h21, 8'h4D, '0);
        run_vec("sm_prefill", v);
        model_run(v);
        pulse_cnt = 0;
        i2c_start();
        send_byte(8'hA0, a);
        send_byte(8'h20, a);
        check("sm_ptr_ack", a, 1'b1);
        for (int i = 0; i < 4; i++) bit_io(1'b1, s);
        check("sm_busy_mid", busy, 1'b1);
        i2c_stop();
        qp();
        check("sm_no_pulse", pulse_cnt, 0);
        check("sm_busy_idle", busy, 1'b0);
        mp = 7'h20;
        v = mkv(1, 0, 7'h50, 8'h00, 1, '0, 1, 0, 7'h00, 8'h00, {24'h0, 8'h3C});
        run_vec("sm_ptr_kept", v);
        model_run(v);

        // Random traffic against the model.
        for (int it = 0; it < 16; it++) begin
            int kind;
            kind     = $urandom_range(0, 3);
            v        = mkv(0, 1, 7'h50, 8'h00, 1, '0, 0, 0, 7'h00, 8'h00, '0);
            v.n      = $urandom_range(1, 3);
            v.idx    = 8'($urandom_range(0, 255));
            v.d      = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
            v.rd     = (kind == 1 || kind == 2);
            v.setp   = (kind != 2);
            if (kind == 3) v.dev = 7'h50 ^ 7'($urandom_range(1, 127));
            model_run(v);
            run_vec($sformatf("rnd%0d_k%0d", it, kind), v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
